sprite_mem_loader: RTL

//  Supplies rgb_pixel to the ship sprite drawer: registered lookup of pixel_addr={y[5:0],x[5:0]}.

---
 rtl/sprite_pkg.sv | 19 +
 rtl/sprite_bank_ram.sv | 38 +++
 rtl/sprite_mem_loader.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types and defaults for the double-buffered ship sprite store.
// No logic; pure declarations.
// Not applicable.
package sprite_pkg;

  localparam int ADDR_W_DEF = 12;  // 64x64 pixels per bank
  localparam int RGB_W_DEF  = 12;  // {R[3:0],G[3:0],B[3:0]}
  localparam int SPRITE_W   = 48;  // visible ship width in pixels
  localparam int SPRITE_H   = 64;  // visible ship height in pixels

  // Load sequencer states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BYTE0     = 2'd1,
    ST_BYTE1     = 2'd2,
    ST_WAIT_SWAP = 2'd3
  } ld_state_e;

endpackage

// File: rtl/sprite_bank_ram.sv
// Simple dual-port pixel RAM holding both sprite banks, address {bank,addr}.
// Read data registered: 1 clk from raddr to rdata.
// No backpressure; one write and one read every cycle.
module sprite_bank_ram #(
  parameter int AW = 13,
  parameter int DW = 12
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  // Write port; storage deliberately has no reset so it maps to block RAM.
  always_ff @(posedge pclk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; only the output register is cleared by reset.
  always_ff @(posedge pclk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sprite_mem_loader.sv
// Double-buffered sprite store: displays front bank, fills back bank from a byte stream.
// Pixel read latency 1 clk; bank swap lands on the first vsync rise after a full load.
// ld_ready low outside BYTE0/BYTE1, so the source stalls while idle or awaiting swap.
module sprite_mem_loader
  import sprite_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RGB_W  = RGB_W_DEF
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pixel_addr,
  output logic [RGB_W-1:0]  rgb_pixel,
  input  logic              vsync_in,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic              load_done,
  output logic              front_bank
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [3:0]        r_q, r_d;
  logic              front_q, front_d;
  logic              done_q, done_d;
  logic              vs_q;
  logic              vs_rise;
  logic              we;

  assign vs_rise  = vsync_in & ~vs_q;
  assign ld_ready = (state_q == ST_BYTE0) || (state_q == ST_BYTE1);

  // Next-state logic: restart beats a same-cycle accept; swap only from WAIT_SWAP.
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    r_d       = r_q;
    front_d   = front_q;
    done_d    = 1'b0;
    we        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ld_start) begin
          state_d   = ST_BYTE0;
          wr_addr_d = '0;
        end
      end
      ST_BYTE0: begin
        if (ld_start) begin
          wr_addr_d = '0;
        end else if (ld_valid) begin
          r_d     = ld_data[3:0];
          state_d = ST_BYTE1;
        end
      end
      ST_BYTE1: begin
        if (ld_start) begin
          wr_addr_d = '0;
          state_d   = ST_BYTE0;
        end else if (ld_valid) begin
          we = 1'b1;
          if (wr_addr_q == LAST_ADDR) begin
            state_d = ST_WAIT_SWAP;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
            state_d   = ST_BYTE0;
          end
        end
      end
      ST_WAIT_SWAP: begin
        if (vs_rise) begin
          front_d = ~front_q;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter, colour latch, vsync history and bank select registers.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_addr_q <= '0;
      r_q       <= '0;
      front_q   <= 1'b0;
      done_q    <= 1'b0;
      vs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      r_q       <= r_d;
      front_q   <= front_d;
      done_q    <= done_d;
      vs_q      <= vsync_in;
    end
  end

  sprite_bank_ram #(
    .AW (ADDR_W + 1),
    .DW (RGB_W)
  ) u_ram (
    .pclk  (pclk),
    .rst   (rst),
    .we    (we),
    .waddr ({~front_q, wr_addr_q}),
    .wdata (RGB_W'({r_q, ld_data})),
    .raddr ({front_q, pixel_addr}),
    .rdata (rgb_pixel)
  );

  assign load_done  = done_q;
  assign front_bank = front_q;

endmodule
